// File: rtl/bcd_2digit_to_binary_pkg.sv
// Shared constants and state encoding for the two-digit BCD to binary converter.
`timescale 1ns/1ps
package bcd_2digit_to_binary_pkg;

    localparam int BCD_MAX    = 9;
    localparam int NUM_SHIFTS = 7;
    localparam int BIN_W      = 7;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 2;
    localparam int CNT_W      = 3;
    localparam int SR_W       = NUM_DIGITS * DIGIT_W + BIN_W;

    // Reverse double-dabble correction: a digit that reached 8+ after the
    // right shift carried a half-ten in from above, so it is pulled back by 3.
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] ADJ_OFFSET = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] digit);
        return digit <= DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of the reverse double-dabble: x >= 8 ? x - 3 : x.
`timescale 1ns/1ps
module bcd_digit_adjust
    import bcd_2digit_to_binary_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= ADJ_THRESH) ? (digit_in - ADJ_OFFSET) : digit_in;

endmodule

// File: rtl/bcd_2digit_to_binary.sv
// Sequential two-digit BCD to 7-bit binary converter (reverse double-dabble,
// one shift per clock, seven shifts per conversion).
`timescale 1ns/1ps
module bcd_2digit_to_binary
    import bcd_2digit_to_binary_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t                          state_reg,  state_next;
    logic [SR_W-1:0]                 shift_reg,  shift_next;
    logic [CNT_W-1:0]                count_reg,  count_next;
    logic [BIN_W-1:0]                bin_reg,    bin_next;
    logic                            done_reg,   done_next;
    logic                            err_reg,    err_next;

    logic [SR_W-1:0]                 shifted;
    logic [NUM_DIGITS*DIGIT_W-1:0]   digits_adj;
    logic [SR_W-1:0]                 adjusted;
    logic                            inputs_valid;

    assign shifted = shift_reg >> 1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_in  (shifted[BIN_W + gi*DIGIT_W +: DIGIT_W]),
                .digit_out (digits_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign adjusted     = {digits_adj, shifted[BIN_W-1:0]};
    assign inputs_valid = digit_valid(tens) && digit_valid(ones);

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        bin_next   = bin_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (inputs_valid) begin
                        shift_next = {tens, ones, {BIN_W{1'b0}}};
                        count_next = '0;
                        state_next = SHIFT;
                    end else begin
                        // Bad digits skip the datapath; bin keeps its last result.
                        state_next = DONE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end
                end
            end

            SHIFT: begin
                shift_next = adjusted;
                count_next = count_reg + 3'd1;
                if (count_reg == CNT_W'(NUM_SHIFTS - 1)) begin
                    count_next = '0;
                    bin_next   = adjusted[BIN_W-1:0];
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            bin_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            count_reg <= count_next;
            bin_reg   <= bin_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign bin  = bin_reg;
    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd_2digit_to_binary.sv
// Bench for bcd_2digit_to_binary: per-cycle timeline model plus directed vectors.
`timescale 1ns/1ps
module tb_bcd_2digit_to_binary;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] bin;
    logic       busy;
    logic       done;
    logic       err;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    bcd_2digit_to_binary dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .tens  (tens),
        .ones  (ones),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: m_k counts cycles since a request was accepted. A valid request
    // is busy for cycles 1..7 and completes in cycle 8; an invalid one
    // completes (with err) in cycle 1. The IDLE cycle is m_k == 0.
    int m_k     = 0;
    bit m_valid = 1'b1;
    int m_val   = 0;
    int m_bin   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k     <= 0;
            m_valid <= 1'b1;
            m_bin   <= 0;
        end else if (m_k == 0) begin
            if (start) begin
                m_k     <= 1;
                m_valid <= (tens <= 4'd9) && (ones <= 4'd9);
                m_val   <= int'(tens) * 10 + int'(ones);
            end
        end else if (m_valid && m_k < 8) begin
            m_k <= m_k + 1;
            if (m_k == 7) m_bin <= m_val;
        end else begin
            m_k <= 0;
        end
    end

    always @(negedge clk) begin : cmp
        int exp_busy, exp_done, exp_err;
        exp_busy = (m_valid && m_k >= 1 && m_k <= 7) ? 1 : 0;
        exp_done = (m_k != 0 && (m_valid ? (m_k == 8) : (m_k == 1))) ? 1 : 0;
        exp_err  = (!m_valid && m_k == 1) ? 1 : 0;
        check("cyc_busy", int'(busy), exp_busy);
        check("cyc_done", int'(done), exp_done);
        check("cyc_err",  int'(err),  exp_err);
        check("cyc_bin",  int'(bin),  m_bin);
    end

    // Called #1 after the accepting edge; returns on the done cycle.
    task automatic wait_result(output int busy_cycles, output int lat,
                               output logic [6:0] b, output logic e);
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) check("conv_timeout", 0, 1);
        b = bin;
        e = err;
    endtask

    task automatic run_conv(input logic [3:0] t, input logic [3:0] o,
                            output int busy_cycles, output int lat,
                            output logic [6:0] b, output logic e);
        @(posedge clk); #1;
        tens  = t;
        ones  = o;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(busy_cycles, lat, b, e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, lat, dn, prev, w;
        logic [6:0] b;
        logic e;

        rst_n = 1'b0;
        start = 1'b0;
        tens  = 4'd0;
        ones  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bin",  int'(bin),  0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err",  int'(err),  0);

        // Start already high at release: accepted on the first edge after it.
        tens  = 4'd4;
        ones  = 4'd2;
        start = 1'b1;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(bc, lat, b, e);
        check("c42_busy_cycles", bc, 7);
        check("c42_latency", lat, 8);
        check("c42_bin", int'(b), 42);
        check("c42_err", int'(e), 0);

        run_conv(4'd9, 4'd9, bc, lat, b, e);
        check("c99_bin", int'(b), 99);
        check("c99_latency", lat, 8);

        run_conv(4'hA, 4'd3, bc, lat, b, e);
        check("bad_latency", lat, 1);
        check("bad_err", int'(e), 1);
        check("bad_bin_kept", int'(b), 99);
        check("bad_busy_cycles", bc, 0);

        run_conv(4'd0, 4'd0, bc, lat, b, e);
        check("c00_bin", int'(b), 0);

        run_conv(4'd3, 4'hF, bc, lat, b, e);
        check("bad_ones_err", int'(e), 1);
        check("bad_ones_bin_kept", int'(b), 0);

        // Start and new digits during SHIFT must be ignored.
        @(posedge clk); #1;
        tens  = 4'd4;
        ones  = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 1) begin
                start = 1'b1;
                tens  = 4'd1;
                ones  = 4'd7;
            end
            if (i == 6) start = 1'b0;
            if (done) begin
                dn++;
                b = bin;
            end
            @(posedge clk); #1;
        end
        check("ign_done_count", dn, 1);
        check("ign_bin", int'(b), 42);

        // Reset in the 4th SHIFT cycle aborts the conversion.
        @(posedge clk); #1;
        tens  = 4'd4;
        ones  = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_bin",  int'(bin),  0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err",  int'(err),  0);
        @(posedge clk); #2 rst_n = 1'b1;
        dn = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        run_conv(4'd5, 4'd5, bc, lat, b, e);
        check("c55_bin", int'(b), 55);
        check("c55_latency", lat, 8);

        // Sweep 00..99 with start held high.
        @(posedge clk); #1;
        tens  = 4'd0;
        ones  = 4'd0;
        start = 1'b1;
        prev  = 0;
        for (int i = 0; i < 100; i++) begin
            w = 0;
            while (!done && w < 30) begin
                @(posedge clk); #1;
                w++;
            end
            if (!done) begin
                check("sweep_timeout", 0, 1);
            end else begin
                check("sweep_bin", int'(bin), i);
                check("sweep_err", int'(err), 0);
                if (i > 0) check("sweep_period", cyc - prev, 9);
                prev = cyc;
            end
            if (i < 99) begin
                tens = 4'((i + 1) / 10);
                ones = 4'((i + 1) % 10);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        repeat (12) @(posedge clk);
        #1;
        check("end_idle_busy", int'(busy), 0);
        check("end_bin", int'(bin), 99);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
